// File: rtl/block_data_memory.sv
// Block-organised data memory behind the data cache.
// Every access moves one whole block and takes LATENCY cycles.
// Handshake:
//   - The requester raises read or write and holds it, together with
//     address, writedata and byteen.
//   - busywait stays high until the access completes.
//   - busywait then drops for exactly one cycle (DONE), during which the
//     requester must release the request.
//   - Read and write high together is illegal: it is rejected with a
//     one-cycle err pulse, and no access is made.
module block_data_memory #(
    parameter int ADDR_WIDTH  = 6,
    parameter int BLOCK_BYTES = 4,
    parameter int LATENCY     = 5
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     read,
    input  logic                     write,
    input  logic [ADDR_WIDTH-1:0]    address,
    input  logic [8*BLOCK_BYTES-1:0] writedata,
    input  logic [BLOCK_BYTES-1:0]   byteen,
    output logic [8*BLOCK_BYTES-1:0] readdata,
    output logic                     busywait,
    output logic                     err,
    output logic [1:0]               o_state
);

    localparam int BYTE_W = $clog2(BLOCK_BYTES);
    localparam int IDX_W  = ADDR_WIDTH + BYTE_W;
    localparam int DEPTH  = BLOCK_BYTES << ADDR_WIDTH;
    localparam int CNT_W  = (LATENCY > 1) ? $clog2(LATENCY) : 1;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(LATENCY - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t                   r_state;
    state_t                   w_next_state;
    logic                     r_op_write;
    logic [ADDR_WIDTH-1:0]    r_addr;
    logic [8*BLOCK_BYTES-1:0] r_wdata;
    logic [BLOCK_BYTES-1:0]   r_byteen;
    logic [CNT_W-1:0]         r_cnt;
    logic [8*BLOCK_BYTES-1:0] r_readdata;
    logic                     r_err;
    logic [7:0]               r_mem [DEPTH];

    logic                     w_req_valid;
    logic                     w_req_conflict;
    logic                     w_accept;
    logic                     w_complete;
    logic [IDX_W-1:0]         w_base;

    assign w_req_valid    = read ^ write;
    assign w_req_conflict = read & write;
    assign w_accept       = (r_state == S_IDLE) && w_req_valid;
    assign w_complete     = (r_state == S_BUSY) && (r_cnt == '0);
    // Byte k of the latched block lives at {r_addr, k}.
    assign w_base         = IDX_W'(r_addr) << BYTE_W;

    assign readdata = r_readdata;
    assign err      = r_err;
    assign o_state  = r_state;

    // State register; reset aborts any access in flight.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next state and busywait.
    // In IDLE, busywait follows the live request so the requester stalls
    // in the request cycle itself.
    always_comb begin
        w_next_state = r_state;
        busywait     = 1'b0;
        case (r_state)
            S_IDLE: begin
                busywait = w_req_valid;
                if (w_req_valid) begin
                    w_next_state = S_BUSY;
                end
            end
            S_BUSY: begin
                busywait = 1'b1;
                if (r_cnt == '0) begin
                    w_next_state = S_DONE;
                end
            end
            S_DONE: begin
                w_next_state = S_IDLE;
            end
            default: begin
                w_next_state = S_IDLE;
            end
        endcase
    end

    // Request latch, latency counter, read-data register and err pulse.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_op_write <= 1'b0;
            r_addr     <= '0;
            r_wdata    <= '0;
            r_byteen   <= '0;
            r_cnt      <= '0;
            r_readdata <= '0;
            r_err      <= 1'b0;
        end else begin
            r_err <= (r_state == S_IDLE) && w_req_conflict;
            if (w_accept) begin
                r_op_write <= write;
                r_addr     <= address;
                r_wdata    <= writedata;
                r_byteen   <= byteen;
                r_cnt      <= CNT_LOAD;
            end else if (r_state == S_BUSY && r_cnt != '0) begin
                r_cnt <= r_cnt - CNT_W'(1);
            end
            if (w_complete && !r_op_write) begin
                for (int k = 0; k < BLOCK_BYTES; k++) begin
                    r_readdata[8*k +: 8] <= r_mem[w_base + IDX_W'(k)];
                end
            end
        end
    end

    // Byte array: cleared on reset, byte-masked block write on completion.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= 8'h00;
            end
        end else if (w_complete && r_op_write) begin
            for (int k = 0; k < BLOCK_BYTES; k++) begin
                if (r_byteen[k]) begin
                    r_mem[w_base + IDX_W'(k)] <= r_wdata[8*k +: 8];
                end
            end
        end
    end

endmodule

// File: tb/tb_block_data_memory.sv
// Bench for block_data_memory.
// Two instances are exercised:
//   - default configuration: 64 blocks x 4 bytes, latency 5;
//   - small configuration: 16 blocks x 8 bytes, latency 1.
// A byte-array reference model predicts each completion's readdata.
// A monitor per instance checks readdata when busywait falls on a live request.
module tb_block_data_memory;

    localparam int LAT_A = 5;
    localparam int LAT_B = 1;

    logic        clock = 1'b0;
    logic        reset;

    logic        rd_a, wr_a;
    logic [5:0]  addr_a;
    logic [31:0] wd_a;
    logic [3:0]  be_a;
    logic [31:0] rdata_a;
    logic        bw_a, err_a;
    logic [1:0]  st_a;

    logic        rd_b, wr_b;
    logic [3:0]  addr_b;
    logic [63:0] wd_b;
    logic [7:0]  be_b;
    logic [63:0] rdata_b;
    logic        bw_b, err_b;
    logic [1:0]  st_b;

    int          pass_cnt  = 0;
    int          total_cnt = 0;
    logic [63:0] exp_q_a[$];
    logic [63:0] exp_q_b[$];
    logic [7:0]  mem_a [256];
    logic [7:0]  mem_b [128];
    logic [63:0] last_a, last_b;
    logic        prev_bw_a = 1'b0;
    logic        prev_bw_b = 1'b0;

    block_data_memory #(.ADDR_WIDTH(6), .BLOCK_BYTES(4), .LATENCY(LAT_A)) dut_a (
        .clock(clock), .reset(reset), .read(rd_a), .write(wr_a), .address(addr_a),
        .writedata(wd_a), .byteen(be_a), .readdata(rdata_a), .busywait(bw_a),
        .err(err_a), .o_state(st_a)
    );

    block_data_memory #(.ADDR_WIDTH(4), .BLOCK_BYTES(8), .LATENCY(LAT_B)) dut_b (
        .clock(clock), .reset(reset), .read(rd_b), .write(wr_b), .address(addr_b),
        .writedata(wd_b), .byteen(be_b), .readdata(rdata_b), .busywait(bw_b),
        .err(err_b), .o_state(st_b)
    );

    // ---------------- clock ----------------
    always #5 clock = ~clock;

    // ---------------- helpers ----------------
    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: actual=%h expected=%h", name, act, exp);
    endtask

    function automatic logic [63:0] rdata(input bit sel);
        return sel ? rdata_b : {32'h0, rdata_a};
    endfunction

    function automatic logic busy(input bit sel);
        return sel ? bw_b : bw_a;
    endfunction

    function automatic logic [7:0] mem_get(input bit sel, input int i);
        return sel ? mem_b[i] : mem_a[i];
    endfunction

    task automatic mem_set(input bit sel, input int i, input logic [7:0] v);
        if (sel) mem_b[i] = v;
        else mem_a[i] = v;
    endtask

    task automatic model_clear();
        for (int i = 0; i < 256; i++) mem_a[i] = 8'h00;
        for (int i = 0; i < 128; i++) mem_b[i] = 8'h00;
        last_a = '0;
        last_b = '0;
    endtask

    task automatic drive(input bit sel, input logic rd, input logic wr, input logic [5:0] addr,
                         input logic [63:0] wd, input logic [7:0] be);
        if (sel) begin
            rd_b = rd; wr_b = wr; addr_b = addr[3:0]; wd_b = wd; be_b = be;
        end else begin
            rd_a = rd; wr_a = wr; addr_a = addr; wd_a = wd[31:0]; be_a = be[3:0];
        end
    endtask

    // ---------------- driver ----------------
    // One complete access: request, model update + expectation push,
    // busywait duration check, release of the request during DONE.
    task automatic access(input bit sel, input bit is_wr, input logic [5:0] addr,
                          input logic [63:0] wd, input logic [7:0] be,
                          input bit move_addr, input logic [5:0] addr2);
        int bb, blk, n, lat;
        logic [63:0] data;
        bb  = sel ? 8 : 4;
        lat = sel ? LAT_B : LAT_A;
        if (sel) addr[5:4] = 2'b00;
        else begin
            wd[63:32] = '0;
            be[7:4]   = '0;
        end
        blk = int'(addr);
        @(posedge clock); #1;
        drive(sel, !is_wr, is_wr, addr, wd, be);
        if (is_wr) begin
            for (int k = 0; k < bb; k++)
                if (be[k]) mem_set(sel, blk * bb + k, wd[8*k +: 8]);
            if (sel) exp_q_b.push_back(last_b);
            else exp_q_a.push_back(last_a);
        end else begin
            data = '0;
            for (int k = 0; k < bb; k++) data[8*k +: 8] = mem_get(sel, blk * bb + k);
            if (sel) begin
                last_b = data; exp_q_b.push_back(data);
            end else begin
                last_a = data; exp_q_a.push_back(data);
            end
        end
        @(negedge clock);
        check(sel ? "b_busy_in_request_cycle" : "a_busy_in_request_cycle", 64'(busy(sel)), 64'd1);
        @(posedge clock);
        n = 0;
        @(negedge clock);
        while (busy(sel) && n < 50) begin
            n++;
            if (move_addr && n == 1) drive(sel, !is_wr, is_wr, addr2, wd, be);
            @(negedge clock);
        end
        check(sel ? "b_busy_cycles" : "a_busy_cycles", 64'(n), 64'(lat));
        #1 drive(sel, 1'b0, 1'b0, move_addr ? addr2 : addr, wd, be);
    endtask

    // ---------------- monitors / scoreboard ----------------
    // Pop and compare each time busywait falls while a request is still held.
    always @(negedge clock) begin
        if (prev_bw_a && !bw_a && (rd_a ^ wr_a)) begin
            if (exp_q_a.size() == 0) begin
                total_cnt++;
                $display("FAIL a_unexpected_completion: readdata=%h with no expected entry", rdata_a);
            end else check("a_readdata", {32'h0, rdata_a}, exp_q_a.pop_front());
        end
        prev_bw_a = bw_a;
    end

    always @(negedge clock) begin
        if (prev_bw_b && !bw_b && (rd_b ^ wr_b)) begin
            if (exp_q_b.size() == 0) begin
                total_cnt++;
                $display("FAIL b_unexpected_completion: readdata=%h with no expected entry", rdata_b);
            end else check("b_readdata", rdata_b, exp_q_b.pop_front());
        end
        prev_bw_b = bw_b;
    end

    // ---------------- watchdog ----------------
    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- stimulus ----------------
    initial begin
        reset = 1'b1;
        drive(1'b0, 1'b0, 1'b0, 6'd0, 64'd0, 8'd0);
        drive(1'b1, 1'b0, 1'b0, 6'd0, 64'd0, 8'd0);
        model_clear();
        repeat (3) @(negedge clock);
        check("rst_a_readdata", {32'h0, rdata_a}, 64'd0);
        check("rst_b_readdata", rdata_b, 64'd0);
        check("rst_a_busywait", 64'(bw_a), 64'd0);
        check("rst_b_busywait", 64'(bw_b), 64'd0);
        check("rst_a_err", 64'(err_a), 64'd0);
        check("rst_b_err", 64'(err_b), 64'd0);
        reset = 1'b0;

        // Full write, then read back.
        access(1'b0, 1'b1, 6'd5, 64'hDEADBEEF, 8'hFF, 1'b0, 6'd0);
        access(1'b0, 1'b0, 6'd5, 64'd0, 8'h00, 1'b0, 6'd0);
        check("t2_full_write", rdata(1'b0), 64'hDEADBEEF);

        // Partial byte-enable write over it.
        access(1'b0, 1'b1, 6'd5, 64'h11223344, 8'b0101, 1'b0, 6'd0);
        access(1'b0, 1'b0, 6'd5, 64'd0, 8'h00, 1'b0, 6'd0);
        check("t3_partial_write", rdata(1'b0), 64'hDE22BE44);

        // Illegal read+write in IDLE.
        @(posedge clock); #1;
        drive(1'b0, 1'b1, 1'b1, 6'd5, 64'hFFFFFFFF, 8'hFF);
        @(negedge clock);
        check("t4_busy_on_conflict", 64'(bw_a), 64'd0);
        check("t4_err_not_early", 64'(err_a), 64'd0);
        @(posedge clock); #1;
        drive(1'b0, 1'b0, 1'b0, 6'd5, 64'd0, 8'h00);
        @(negedge clock);
        check("t4_err_pulse", 64'(err_a), 64'd1);
        check("t4_busy_after_conflict", 64'(bw_a), 64'd0);
        @(negedge clock);
        check("t4_err_one_cycle", 64'(err_a), 64'd0);
        access(1'b0, 1'b0, 6'd5, 64'd0, 8'h00, 1'b0, 6'd0);
        check("t4_memory_unchanged", rdata(1'b0), 64'hDE22BE44);

        // Address moved mid-access has no effect.
        access(1'b0, 1'b1, 6'd7, 64'hA5A50707, 8'hFF, 1'b0, 6'd0);
        access(1'b0, 1'b1, 6'd9, 64'h5A5A0909, 8'hFF, 1'b0, 6'd0);
        access(1'b0, 1'b0, 6'd7, 64'd0, 8'h00, 1'b1, 6'd9);
        check("t5_latched_address", rdata(1'b0), 64'hA5A50707);

        // Small configuration: top block, byte ordering, latency 1.
        access(1'b1, 1'b1, 6'd15, 64'hDEADBEEF_CAFEF00D, 8'hFF, 1'b0, 6'd0);
        access(1'b1, 1'b1, 6'd0, 64'h01020304_05060708, 8'hFF, 1'b0, 6'd0);
        access(1'b1, 1'b0, 6'd15, 64'd0, 8'h00, 1'b0, 6'd0);
        check("t6_b_full_write", rdata(1'b1), 64'hDEADBEEF_CAFEF00D);
        access(1'b1, 1'b1, 6'd15, 64'h11223344_55667788, 8'b0101_0101, 1'b0, 6'd0);
        access(1'b1, 1'b0, 6'd15, 64'd0, 8'h00, 1'b0, 6'd0);
        check("t6_b_partial_write", rdata(1'b1), 64'hDE22BE44_CA66F088);
        access(1'b1, 1'b0, 6'd0, 64'd0, 8'h00, 1'b0, 6'd0);
        check("t6_b_block0", rdata(1'b1), 64'h01020304_05060708);

        // Reset in the middle of a write to block 3.
        access(1'b0, 1'b1, 6'd3, 64'hCAFEF00D, 8'hFF, 1'b0, 6'd0);
        access(1'b0, 1'b0, 6'd3, 64'd0, 8'h00, 1'b0, 6'd0);
        @(posedge clock); #1;
        drive(1'b0, 1'b0, 1'b1, 6'd3, 64'h12345678, 8'hFF);
        @(posedge clock);
        @(negedge clock);
        check("t1_busy_mid_access", 64'(bw_a), 64'd1);
        reset = 1'b1;
        drive(1'b0, 1'b0, 1'b0, 6'd3, 64'd0, 8'h00);
        #1;
        check("t1_busy_drops_in_reset", 64'(bw_a), 64'd0);
        check("t1_a_readdata_cleared", {32'h0, rdata_a}, 64'd0);
        check("t1_b_readdata_cleared", rdata_b, 64'd0);
        model_clear();
        @(negedge clock);
        reset = 1'b0;
        access(1'b0, 1'b0, 6'd3, 64'd0, 8'h00, 1'b0, 6'd0);
        check("t1_block3_cleared", rdata(1'b0), 64'd0);
        access(1'b1, 1'b0, 6'd15, 64'd0, 8'h00, 1'b0, 6'd0);
        check("t1_b_block15_cleared", rdata(1'b1), 64'd0);

        // Randomized traffic on both instances against the model.
        for (int i = 0; i < 60; i++) begin
            access(1'(i % 2), 1'($urandom_range(0, 1)), 6'($urandom_range(0, 63)),
                   {$urandom, $urandom}, 8'($urandom_range(0, 255)), 1'b0, 6'd0);
            repeat ($urandom_range(0, 2)) @(posedge clock);
        end

        repeat (4) @(negedge clock);
        check("a_queue_drained", 64'(exp_q_a.size()), 64'd0);
        check("b_queue_drained", 64'(exp_q_b.size()), 64'd0);
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
